irq_controller: RTL and testbench
=================================

# irq_controller

Parametrised multi-source IRQ controller sitting between external interrupt lines and the ARMv7 core's exception logic. Synchronises N request lines, latches each as edge- or level-triggered, masks per channel and globally via CPSR bit 7, and selects one fixed-priority winner. Raises INT_irq to the core with a stable channel ID and handler vector, then tracks the acknowledged channel as in-service until end-of-interrupt.

## Interface
- N_IRQ, 4: number of request channels (1..32).
- ID_W, 2: width of irq_id; must satisfy 2^ID_W >= N_IRQ.
- SYNC_STAGES, 2: synchroniser depth per EX_irq line (>=1).
- VEC_BASE, 32'h0000_0018: vector for channel 0.
- VEC_STRIDE, 4: byte spacing between channel vectors.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- CPSR_7  input  1  CPSR I bit; 1 = IRQs globally disabled.
- EX_irq  input  N_IRQ  asynchronous request lines, active-high.
- trig_mode  input  N_IRQ  per channel: 1 = rising-edge, 0 = level.
- irq_mask  input  N_IRQ  per channel: 1 = masked.
- INTA_irq  input  1  one-cycle acknowledge pulse from the core.
- eoi  input  1  one-cycle end-of-interrupt pulse from the handler.
- INT_irq  output  1  registered interrupt request to the core.
- irq_id  output  ID_W  winning channel; valid while INT_irq=1 and in SERVICE.
- irq_vector  output  32  VEC_BASE + irq_id*VEC_STRIDE, 32-bit wraparound.
- pending  output  N_IRQ  raw pending bits, before masking.
- in_service  output  N_IRQ  one-hot channel being serviced, or zero.

## Operation
- Synchroniser: each EX_irq bit passes through SYNC_STAGES flops. A previous-value flop on the synchroniser output provides edge detection.
- Pending, edge mode: set on a synchronised 0->1 transition. Cleared only by INTA_irq for that channel while in REQ. If set and clear occur in the same cycle, set wins.
- Pending, level mode: equals the synchronised level. INTA_irq does not clear it.
- Eligible vector: pending & ~irq_mask. Winner is the lowest-index eligible bit (channel 0 has highest priority).
- FSM states:
  - IDLE: INT_irq=0. If CPSR_7=0 and eligible!=0, latch irq_id := winner and go to REQ.
  - REQ: INT_irq=1. irq_id is frozen; there is no re-arbitration, even if a higher-priority channel arrives.
    - If CPSR_7=1, or the latched channel is no longer eligible (masked, or level dropped), go to IDLE. INT_irq falls, and re-arbitration happens from IDLE.
    - On INTA_irq=1: set in_service[irq_id], clear pending[irq_id] if in edge mode, go to SERVICE. The abort condition and INTA_irq in the same cycle: INTA wins.
  - SERVICE: INT_irq=0 and irq_id is held. No nesting: further requests stay pending. On eoi=1: clear in_service, go to IDLE.
- Ignored inputs: INTA_irq outside REQ, and eoi outside SERVICE.
- A level-mode channel that is still high after eoi re-requests through IDLE.

## Timing
- Reset (rst=0, asynchronous) forces: all synchroniser and edge flops to 0, pending=0, in_service=0, state=IDLE, INT_irq=0, irq_id=0, irq_vector=VEC_BASE.
- Reset asserted mid-operation aborts any REQ or SERVICE immediately. Requests are lost.
- Release is synchronous to the first clk edge after rst=1.
- Latency: EX_irq rises before edge E0.
  - pending bit is 1 after edge E0+SYNC_STAGES.
  - INT_irq is 1 after edge E0+SYNC_STAGES+1, provided CPSR_7=0, the channel is unmasked, and the FSM is in IDLE.
- irq_id and irq_vector change only on the IDLE->REQ transition and at reset.
- INTA_irq sampled at edge K in REQ: INT_irq=0 and in_service set after edge K.
- eoi sampled at edge K in SERVICE: in_service=0 after edge K. The earliest next INT_irq is after edge K+2.
- All outputs are registered, except irq_vector, which is combinational from the irq_id register.

## Test plan
- Reset/basic (defaults, edge mode): pulse EX_irq[2] before E0 -> pending[2]=1 after E2, INT_irq=1 with irq_id=2 and irq_vector=0x20 after E3. INTA at E5 -> INT_irq=0 and in_service=4'b0100. eoi at E8 -> in_service=0 and the FSM stays idle.
- Priority: raise EX_irq[3] and EX_irq[1] together -> irq_id=1. After INTA and eoi for channel 1 -> irq_id=3 reported next.
- Global mask: CPSR_7=1 with EX_irq[0] edge -> pending[0]=1 and INT_irq stays 0. Set CPSR_7=0 -> INT_irq=1 one cycle later. Set CPSR_7=1 during REQ -> INT_irq drops the next edge and pending[0] is retained.
- Level mode: trig_mode[1]=0 and hold EX_irq[1]=1 through eoi -> a second INT_irq with irq_id=1. Drop the level during REQ -> return to IDLE with no INTA.
- Edge during service: a new edge on ch0 while ch0 is in SERVICE -> pending[0]=1, and a new INT_irq follows eoi. An edge coinciding with INTA clear -> pending stays 1.
- Asynchronous reset in SERVICE: rst=0 mid-cycle -> INT_irq, pending and in_service are 0 immediately. Stray INTA/eoi after release are ignored.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller: synchronise, latch, mask and prioritise N request lines into one core IRQ.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   CPSR_7     global IRQ disable (1 = disabled)
//   EX_irq     asynchronous active-high request lines
//   trig_mode  per channel: 1 = rising edge, 0 = level
//   irq_mask   per channel: 1 = masked
//   INTA_irq   one-cycle acknowledge from the core
//   eoi        one-cycle end-of-interrupt from the handler
//   INT_irq    registered interrupt request to the core
//   irq_id     latched winning channel
//   irq_vector handler vector for irq_id
//   pending    raw pending bits before masking
//   in_service one-hot channel being serviced, or zero
module irq_controller #(
    parameter int          N_IRQ       = 4,
    parameter int          ID_W        = 2,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0018,
    parameter int          VEC_STRIDE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CPSR_7,
    input  logic [N_IRQ-1:0] EX_irq,
    input  logic [N_IRQ-1:0] trig_mode,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             INTA_irq,
    input  logic             eoi,
    output logic             INT_irq,
    output logic [ID_W-1:0]  irq_id,
    output logic [31:0]      irq_vector,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
    logic [N_IRQ-1:0] prev_q, sync_out, rise, eligible, inta_clr, pending_next;
    logic [ID_W-1:0] winner;
    logic eoi_gap;
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise = sync_out & ~prev_q;
    assign eligible = pending & ~irq_mask;
    assign inta_clr = (state == REQ && INTA_irq) ? (N_IRQ'(1) << irq_id) : '0;
    // edge channels: a new rise beats a same-cycle acknowledge clear; level channels track the line
    assign pending_next = (trig_mode & ((pending & ~inta_clr) | rise)) | (~trig_mode & sync_out);
    assign irq_vector = VEC_BASE + 32'(irq_id) * 32'(VEC_STRIDE);
    always_comb begin
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (eligible[i]) winner = ID_W'(i);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            prev_q  <= '0;
            pending <= '0;
        end else begin
            sync_q[0] <= EX_irq;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q  <= sync_out;
            pending <= pending_next;
        end
    end
    // eoi_gap holds IDLE for one cycle after eoi so the next request is raised no sooner than two edges later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            INT_irq    <= 1'b0;
            irq_id     <= '0;
            in_service <= '0;
            eoi_gap    <= 1'b0;
        end else begin
            eoi_gap <= 1'b0;
            case (state)
                IDLE: if (!CPSR_7 && !eoi_gap && |eligible) begin
                    irq_id  <= winner;
                    INT_irq <= 1'b1;
                    state   <= REQ;
                end
                REQ: if (INTA_irq) begin
                    in_service <= N_IRQ'(1) << irq_id;
                    INT_irq    <= 1'b0;
                    state      <= SERVICE;
                end else if (CPSR_7 || !eligible[irq_id]) begin
                    INT_irq <= 1'b0;
                    state   <= IDLE;
                end
                SERVICE: if (eoi) begin
                    in_service <= '0;
                    eoi_gap    <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed self-checking bench for irq_controller with default parameters.
// Ports: none (drives clk, rst and all request/handshake inputs of the DUT).
module tb_irq_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        CPSR_7;
    logic [3:0]  EX_irq;
    logic [3:0]  trig_mode;
    logic [3:0]  irq_mask;
    logic        INTA_irq;
    logic        eoi;
    logic        INT_irq;
    logic [1:0]  irq_id;
    logic [31:0] irq_vector;
    logic [3:0]  pending;
    logic [3:0]  in_service;
    int vectors = 0;
    int miscompares = 0;

    irq_controller dut (
        .clk(clk), .rst(rst), .CPSR_7(CPSR_7), .EX_irq(EX_irq),
        .trig_mode(trig_mode), .irq_mask(irq_mask), .INTA_irq(INTA_irq), .eoi(eoi),
        .INT_irq(INT_irq), .irq_id(irq_id), .irq_vector(irq_vector),
        .pending(pending), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; CPSR_7 = 1'b0; EX_irq = 4'b0; trig_mode = 4'b1111;
        irq_mask = 4'b0; INTA_irq = 1'b0; eoi = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_int", 32'(INT_irq), 32'h0);
        chk("rst_id", 32'(irq_id), 32'h0);
        chk("rst_vec", irq_vector, 32'h18);
        chk("rst_pend", 32'(pending), 32'h0);
        chk("rst_isvc", 32'(in_service), 32'h0);
        cyc(2);
        rst = 1'b1;
        // basic edge-mode request on channel 2
        EX_irq = 4'b0100;
        cyc(1);
        EX_irq = 4'b0;
        cyc(1);
        chk("b_pend_e1", 32'(pending), 32'h0);
        cyc(1);
        chk("b_pend_e2", 32'(pending), 32'h4);
        chk("b_int_e2", 32'(INT_irq), 32'h0);
        cyc(1);
        chk("b_int_e3", 32'(INT_irq), 32'h1);
        chk("b_id_e3", 32'(irq_id), 32'h2);
        chk("b_vec_e3", irq_vector, 32'h20);
        cyc(1);
        INTA_irq = 1'b1;
        cyc(1);
        INTA_irq = 1'b0;
        chk("b_int_e5", 32'(INT_irq), 32'h0);
        chk("b_isvc_e5", 32'(in_service), 32'h4);
        chk("b_pend_e5", 32'(pending), 32'h0);
        cyc(2);
        eoi = 1'b1;
        cyc(1);
        eoi = 1'b0;
        chk("b_isvc_e8", 32'(in_service), 32'h0);
        cyc(2);
        chk("b_idle", 32'(INT_irq), 32'h0);
        // priority: channels 3 and 1 together
        EX_irq = 4'b1010;
        cyc(1);
        EX_irq = 4'b0;
        cyc(2);
        chk("p_pend", 32'(pending), 32'ha);
        cyc(1);
        chk("p_int", 32'(INT_irq), 32'h1);
        chk("p_id1", 32'(irq_id), 32'h1);
        chk("p_vec1", irq_vector, 32'h1c);
        INTA_irq = 1'b1;
        cyc(1);
        INTA_irq = 1'b0;
        chk("p_isvc1", 32'(in_service), 32'h2);
        chk("p_pend_left", 32'(pending), 32'h8);
        eoi = 1'b1;
        cyc(1);
        eoi = 1'b0;
        chk("p_isvc_clr", 32'(in_service), 32'h0);
        cyc(1);
        chk("p_gap", 32'(INT_irq), 32'h0);
        cyc(1);
        chk("p_int3", 32'(INT_irq), 32'h1);
        chk("p_id3", 32'(irq_id), 32'h3);
        chk("p_vec3", irq_vector, 32'h24);
        INTA_irq = 1'b1;
        cyc(1);
        INTA_irq = 1'b0;
        eoi = 1'b1;
        cyc(1);
        eoi = 1'b0;
        cyc(2);
        chk("p_done_pend", 32'(pending), 32'h0);
        // global mask via CPSR_7
        CPSR_7 = 1'b1;
        EX_irq = 4'b0001;
        cyc(1);
        EX_irq = 4'b0;
        cyc(2);
        chk("g_pend", 32'(pending), 32'h1);
        cyc(2);
        chk("g_int_masked", 32'(INT_irq), 32'h0);
        CPSR_7 = 1'b0;
        cyc(1);
        chk("g_int_on", 32'(INT_irq), 32'h1);
        chk("g_id0", 32'(irq_id), 32'h0);
        CPSR_7 = 1'b1;
        cyc(1);
        chk("g_int_abort", 32'(INT_irq), 32'h0);
        chk("g_pend_kept", 32'(pending), 32'h1);
        CPSR_7 = 1'b0;
        cyc(1);
        chk("g_int_rearb", 32'(INT_irq), 32'h1);
        INTA_irq = 1'b1;
        cyc(1);
        INTA_irq = 1'b0;
        eoi = 1'b1;
        cyc(1);
        eoi = 1'b0;
        cyc(2);
        // level mode on channel 1
        trig_mode = 4'b1101;
        EX_irq = 4'b0010;
        cyc(3);
        chk("l_pend", 32'(pending), 32'h2);
        cyc(1);
        chk("l_int1", 32'(INT_irq), 32'h1);
        chk("l_id1", 32'(irq_id), 32'h1);
        INTA_irq = 1'b1;
        cyc(1);
        INTA_irq = 1'b0;
        chk("l_isvc", 32'(in_service), 32'h2);
        chk("l_pend_held", 32'(pending), 32'h2);
        eoi = 1'b1;
        cyc(1);
        eoi = 1'b0;
        cyc(1);
        chk("l_gap", 32'(INT_irq), 32'h0);
        cyc(1);
        chk("l_int2", 32'(INT_irq), 32'h1);
        chk("l_id2", 32'(irq_id), 32'h1);
        EX_irq = 4'b0;
        cyc(3);
        chk("l_pend_drop", 32'(pending), 32'h0);
        chk("l_int_still", 32'(INT_irq), 32'h1);
        cyc(1);
        chk("l_int_abort", 32'(INT_irq), 32'h0);
        chk("l_isvc_none", 32'(in_service), 32'h0);
        // edges arriving during service and coinciding with acknowledge
        trig_mode = 4'b1111;
        EX_irq = 4'b0001;
        cyc(1);
        EX_irq = 4'b0;
        cyc(3);
        chk("s_int", 32'(INT_irq), 32'h1);
        chk("s_id", 32'(irq_id), 32'h0);
        INTA_irq = 1'b1;
        cyc(1);
        INTA_irq = 1'b0;
        chk("s_isvc", 32'(in_service), 32'h1);
        chk("s_pend_clr", 32'(pending), 32'h0);
        EX_irq = 4'b0001;
        cyc(1);
        EX_irq = 4'b0;
        cyc(2);
        chk("s_pend_new", 32'(pending), 32'h1);
        chk("s_no_nest", 32'(INT_irq), 32'h0);
        eoi = 1'b1;
        cyc(1);
        eoi = 1'b0;
        chk("s_isvc_clr", 32'(in_service), 32'h0);
        cyc(1);
        chk("s_gap", 32'(INT_irq), 32'h0);
        cyc(1);
        chk("s_int_again", 32'(INT_irq), 32'h1);
        EX_irq = 4'b0001;
        cyc(1);
        EX_irq = 4'b0;
        cyc(1);
        INTA_irq = 1'b1;
        cyc(1);
        INTA_irq = 1'b0;
        chk("c_pend_setwins", 32'(pending), 32'h1);
        chk("c_isvc", 32'(in_service), 32'h1);
        eoi = 1'b1;
        cyc(1);
        eoi = 1'b0;
        cyc(2);
        chk("c_int_after", 32'(INT_irq), 32'h1);
        // asynchronous reset while in service
        INTA_irq = 1'b1;
        cyc(1);
        INTA_irq = 1'b0;
        EX_irq = 4'b1000;
        cyc(1);
        EX_irq = 4'b0;
        cyc(2);
        chk("r_pend_pre", 32'(pending), 32'h8);
        chk("r_isvc_pre", 32'(in_service), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("r_int", 32'(INT_irq), 32'h0);
        chk("r_pend", 32'(pending), 32'h0);
        chk("r_isvc", 32'(in_service), 32'h0);
        chk("r_vec", irq_vector, 32'h18);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        INTA_irq = 1'b1;
        cyc(1);
        INTA_irq = 1'b0;
        eoi = 1'b1;
        cyc(1);
        eoi = 1'b0;
        cyc(2);
        chk("r_stray_int", 32'(INT_irq), 32'h0);
        chk("r_stray_isvc", 32'(in_service), 32'h0);
        chk("r_stray_pend", 32'(pending), 32'h0);
        // per-channel mask
        irq_mask = 4'b0100;
        EX_irq = 4'b0100;
        cyc(1);
        EX_irq = 4'b0;
        cyc(2);
        chk("m_pend", 32'(pending), 32'h4);
        cyc(2);
        chk("m_int_masked", 32'(INT_irq), 32'h0);
        irq_mask = 4'b0;
        cyc(1);
        chk("m_int_on", 32'(INT_irq), 32'h1);
        chk("m_vec", irq_vector, 32'h20);
        irq_mask = 4'b0100;
        cyc(1);
        chk("m_int_abort", 32'(INT_irq), 32'h0);
        chk("m_pend_kept", 32'(pending), 32'h4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
